data_ram_access_unit: RTL and testbench
=======================================

Name: data_ram_access_unit

Overview:
- Processor-side initiator for the single-port data RAM.
- Accepts load, store and block-copy requests from the core over a request/ready handshake.
- Sequences the RAM port signals (address, write data, write enable) and returns read data with a done pulse and an error flag.
- Sits between the execute stage and the data RAM. It is the only driver of the RAM port.

Parameters:
- ADDRESS_WIDTH, 10, width of RAM word address and copy length
- DATA_WIDTH, 32, RAM word width
- RAM_DEPTH, 1024, number of valid words; addresses >= RAM_DEPTH are out of range

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- request  input  1  core request strobe, sampled only when ready=1
- operation  input  2  00 load, 01 store, 10 copy, 11 illegal
- cpuAddress  input  ADDRESS_WIDTH  load/store address; copy source base
- cpuData  input  DATA_WIDTH  store data
- copyDestination  input  ADDRESS_WIDTH  copy destination base
- copyLength  input  ADDRESS_WIDTH  copy word count (0 allowed)
- ready  output  1  high only in IDLE
- done  output  1  one-cycle pulse on completion
- error  output  1  valid while done=1
- loadData  output  DATA_WIDTH  last loaded word, held until next load completes
- ramAddress  output  ADDRESS_WIDTH  to RAM address
- ramDataC  output  DATA_WIDTH  to RAM write data
- ramWriteEnable  output  1  to RAM write enable
- ramDataOutput  input  DATA_WIDTH  RAM read data, combinational from ramAddress

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. loadData, ramAddress, ramDataC, ramWriteEnable, done and error are all 0. ready=1.
- Reset mid-operation: ramWriteEnable drops immediately. A partially completed copy is left as is, with no rollback.
- States: IDLE, LOAD, STORE, COPY_READ, COPY_WRITE, DONE. All outputs are registered or decoded from state; there is no combinational path from request to the RAM port.
- Accept: at a rising edge with state=IDLE and request=1, latch operation, cpuAddress, cpuData, copyDestination and copyLength. Compute the range check in ADDRESS_WIDTH+1 bits. request is ignored when ready=0.
- Error conditions (request goes straight to DONE with error=1 and no RAM write):
  - operation=11.
  - Load/store with address >= RAM_DEPTH.
  - Copy with source+length > RAM_DEPTH or destination+length > RAM_DEPTH.
- Load: the LOAD cycle drives ramAddress=addr with ramWriteEnable=0. At the end of LOAD, loadData<=ramDataOutput, then go to DONE.
  - done asserts 2 cycles after the accept edge.
- Store: the STORE cycle drives ramAddress=addr, ramDataC=data, ramWriteEnable=1 for exactly one cycle, then go to DONE.
- Copy with internal word counter i = 0..length-1:
  - COPY_READ: ramAddress=source+i, we=0. Capture ramDataOutput into an internal buffer.
  - COPY_WRITE: ramAddress=destination+i, ramDataC=buffer, we=1. Increment i.
  - Return to COPY_READ while i<length, else go to DONE.
  - Copying is strictly ascending. An overlap with destination>source replicates the source pattern; this is the defined behaviour.
  - length=0: go to DONE directly, error=0, no RAM activity.
  - Latency: done at accept+1+2*length cycles.
- DONE: done=1 for one cycle, error as determined, ready=0. The next state is IDLE.
  - A new request can be accepted the cycle after DONE.
- Outside STORE and COPY_WRITE, ramWriteEnable=0.
- The address is held stable across each RAM cycle.
- loadData changes only at the end of LOAD.

Test Plan:
- Reset, then store 0x0000_00A5 to address 3, then load address 3. Required: ramWriteEnable high for exactly 1 cycle; done 2 cycles after each accept; loadData=0x0000_00A5; error=0.
- Preload words 0..3 = 1,3,5,9, then copy source=0, destination=10, length=4. Required: RAM[10..13]=1,3,5,9; done at accept+9; exactly 4 write pulses to addresses 10,11,12,13.
- Copy with length=0, then copy source=1020, destination=0, length=8. Required: first gives done at accept+1 with error=0; second gives error=1 and no write pulse.
- Load address 1023 (ok, error=0); operation=11 (error=1); request held high while busy. Required: only one accept per IDLE; ready low from accept until after DONE.
- Overlap copy of words 0..2=7,8,9 with source=0, destination=1, length=3. Required: RAM[1..3]=7,7,7.
- Assert reset during COPY_WRITE of word 2 of 4. Required: ramWriteEnable drops immediately; ready=1 and all outputs 0; words 0–1 copied; word 2 may or may not be written; word 3 not written.

Source files
------------

// File: rtl/data_ram_access_unit.sv
// data_ram_access_unit: sole initiator on the single-port data RAM.
// Takes load / store / block-copy requests from the core over a
// request/ready handshake and sequences the RAM address, write data and
// write enable. Read data is returned on loadData_o with a done pulse and
// an error flag.
//
// state        | meaning
// -------------+-------------------------------------------------------
// S_IDLE       | ready, waiting for a request
// S_LOAD       | RAM read cycle for a load, result captured at its end
// S_STORE      | single RAM write cycle for a store
// S_COPY_READ  | read source word of a copy into the buffer
// S_COPY_WRITE | write buffered word to destination, advance pointers
// S_DONE       | one-cycle completion pulse, error valid
module data_ram_access_unit #(
  parameter int ADDRESS_WIDTH = 10,
  parameter int DATA_WIDTH    = 32,
  parameter int RAM_DEPTH     = 1024
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     request_i,
  input  logic [1:0]               operation_i,
  input  logic [ADDRESS_WIDTH-1:0] cpuAddress_i,
  input  logic [DATA_WIDTH-1:0]    cpuData_i,
  input  logic [ADDRESS_WIDTH-1:0] copyDestination_i,
  input  logic [ADDRESS_WIDTH-1:0] copyLength_i,
  output logic                     ready_o,
  output logic                     done_o,
  output logic                     error_o,
  output logic [DATA_WIDTH-1:0]    loadData_o,
  output logic [ADDRESS_WIDTH-1:0] ramAddress_o,
  output logic [DATA_WIDTH-1:0]    ramDataC_o,
  output logic                     ramWriteEnable_o,
  input  logic [DATA_WIDTH-1:0]    ramDataOutput_i
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_LOAD       = 3'd1;
  localparam logic [2:0] S_STORE      = 3'd2;
  localparam logic [2:0] S_COPY_READ  = 3'd3;
  localparam logic [2:0] S_COPY_WRITE = 3'd4;
  localparam logic [2:0] S_DONE       = 3'd5;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_COPY  = 2'b10;

  // One extra bit so base+length never wraps before the depth compare.
  localparam logic [ADDRESS_WIDTH:0] DEPTH_EXT = (ADDRESS_WIDTH+1)'(RAM_DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] ONE     = ADDRESS_WIDTH'(1);

  logic [2:0]               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] src_q, src_d;
  logic [ADDRESS_WIDTH-1:0] dst_q, dst_d;
  logic [ADDRESS_WIDTH-1:0] rem_q, rem_d;
  logic [ADDRESS_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]    ram_wdata_q, ram_wdata_d;
  logic [DATA_WIDTH-1:0]    load_data_q, load_data_d;
  logic                     error_q, error_d;

  logic [ADDRESS_WIDTH:0]   addr_ext;
  logic [ADDRESS_WIDTH:0]   src_end;
  logic [ADDRESS_WIDTH:0]   dst_end;
  logic                     addr_oor;
  logic                     copy_oor;

  assign addr_ext = {1'b0, cpuAddress_i};
  assign src_end  = {1'b0, cpuAddress_i} + {1'b0, copyLength_i};
  assign dst_end  = {1'b0, copyDestination_i} + {1'b0, copyLength_i};
  assign addr_oor = (addr_ext >= DEPTH_EXT);
  assign copy_oor = (src_end > DEPTH_EXT) || (dst_end > DEPTH_EXT);

  // Next-state and datapath decisions; the RAM port is only ever loaded
  // from registers so request never reaches the RAM combinationally.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    rem_d       = rem_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    load_data_d = load_data_q;
    error_d     = error_q;
    case (state_q)
      S_IDLE: begin
        if (request_i) begin
          error_d = 1'b0;
          case (operation_i)
            OP_LOAD, OP_STORE: begin
              if (addr_oor) begin
                error_d = 1'b1;
                state_d = S_DONE;
              end else begin
                ram_addr_d = cpuAddress_i;
                if (operation_i == OP_STORE) begin
                  ram_wdata_d = cpuData_i;
                  state_d     = S_STORE;
                end else begin
                  state_d = S_LOAD;
                end
              end
            end
            OP_COPY: begin
              if (copy_oor) begin
                error_d = 1'b1;
                state_d = S_DONE;
              end else if (copyLength_i == '0) begin
                state_d = S_DONE;
              end else begin
                src_d      = cpuAddress_i;
                dst_d      = copyDestination_i;
                rem_d      = copyLength_i;
                ram_addr_d = cpuAddress_i;
                state_d    = S_COPY_READ;
              end
            end
            default: begin
              error_d = 1'b1;
              state_d = S_DONE;
            end
          endcase
        end
      end
      S_LOAD: begin
        load_data_d = ramDataOutput_i;
        state_d     = S_DONE;
      end
      S_STORE: begin
        state_d = S_DONE;
      end
      S_COPY_READ: begin
        // The write-data register doubles as the copy buffer.
        ram_wdata_d = ramDataOutput_i;
        ram_addr_d  = dst_q;
        state_d     = S_COPY_WRITE;
      end
      S_COPY_WRITE: begin
        rem_d = rem_q - ONE;
        src_d = src_q + ONE;
        dst_d = dst_q + ONE;
        if (rem_q == ONE) begin
          state_d = S_DONE;
        end else begin
          ram_addr_d = src_q + ONE;
          state_d    = S_COPY_READ;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= S_IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      rem_q       <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      load_data_q <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      rem_q       <= rem_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      load_data_q <= load_data_d;
      error_q     <= error_d;
    end
  end

  // Write enable is decoded from state so reset removes it immediately.
  assign ramWriteEnable_o = (state_q == S_STORE) || (state_q == S_COPY_WRITE);
  assign ready_o          = (state_q == S_IDLE);
  assign done_o           = (state_q == S_DONE);
  assign error_o          = (state_q == S_DONE) && error_q;
  assign loadData_o       = load_data_q;
  assign ramAddress_o     = ram_addr_q;
  assign ramDataC_o       = ram_wdata_q;

endmodule

// File: tb/tb_data_ram_access_unit.sv
// Bench for data_ram_access_unit: RAM model, directed scenarios, random
// operations, and a per-cycle comparison against a transaction-level model.
module tb_data_ram_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        request;
  logic [1:0]  operation;
  logic [9:0]  cpu_address;
  logic [31:0] cpu_data;
  logic [9:0]  copy_dst;
  logic [9:0]  copy_len;
  logic        ready, done, error, ram_we;
  logic [31:0] load_data, ram_data_c, ram_data_out;
  logic [9:0]  ram_address;

  data_ram_access_unit #(.ADDRESS_WIDTH(10), .DATA_WIDTH(32), .RAM_DEPTH(1024)) dut (
    .clock_i(clk), .reset_i(rst_n), .request_i(request), .operation_i(operation),
    .cpuAddress_i(cpu_address), .cpuData_i(cpu_data), .copyDestination_i(copy_dst),
    .copyLength_i(copy_len), .ready_o(ready), .done_o(done), .error_o(error),
    .loadData_o(load_data), .ramAddress_o(ram_address), .ramDataC_o(ram_data_c),
    .ramWriteEnable_o(ram_we), .ramDataOutput_i(ram_data_out)
  );

  always #5 clk = ~clk;

  // RAM with combinational read, plus bench-side fill and preload paths.
  logic [31:0] ram [1024];
  logic        fill, pre_we;
  logic [9:0]  pre_addr;
  logic [31:0] pre_data;
  assign ram_data_out = ram[ram_address];

  function automatic logic [31:0] pat(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'hC001_D00D;
  endfunction

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 1024; i++) ram[i] <= pat(i);
    end else if (pre_we) begin
      ram[pre_addr] <= pre_data;
    end else if (ram_we) begin
      ram[ram_address] <= ram_data_c;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected per-cycle view of one transaction.
  typedef struct {
    bit          ready, done, err, we, chk_addr;
    logic [9:0]  addr;
    logic [31:0] data;
    logic [31:0] load;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  logic [31:0] model_mem [1024];
  logic [31:0] model_load = '0;
  bit          checking = 0;
  int          vectors = 0, miscompares = 0;
  int          accept_cyc = 0, done_cyc = 0, wpulse = 0;
  logic        last_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic exp_t mk(input bit rdy, input bit dn, input bit er, input bit we,
                              input bit ca, input int addr, input logic [31:0] data,
                              input logic [31:0] ld);
    exp_t e;
    e.ready = rdy; e.done = dn; e.err = er; e.we = we; e.chk_addr = ca;
    e.addr = 10'(addr); e.data = data; e.load = ld;
    return e;
  endfunction

  // Per-cycle compare against the model timeline.
  always @(negedge clk) begin
    if (checking) begin
      if (q.size() > 0) cur = q.pop_front();
      else cur = mk(1, 0, 0, 0, 0, 0, 32'h0, model_load);
      chk("ready", 32'(ready), 32'(cur.ready));
      chk("done", 32'(done), 32'(cur.done));
      chk("we", 32'(ram_we), 32'(cur.we));
      chk("load_data", load_data, cur.load);
      if (cur.done) chk("error", 32'(error), 32'(cur.err));
      if (cur.chk_addr) chk("ram_address", 32'(ram_address), 32'(cur.addr));
      if (cur.we) chk("ram_data_c", ram_data_c, cur.data);
      if (done) begin done_cyc = cyc; last_err = error; end
      if (ram_we) wpulse++;
    end
  end

  // Transaction-level model: what the RAM port must show cycle by cycle.
  task automatic build(input logic [1:0] op, input logic [9:0] a, input logic [31:0] d,
                       input logic [9:0] dst, input logic [9:0] len);
    bit err;
    logic [31:0] old, v;
    old = model_load;
    err = (op == 2'b11) || (op < 2'b10 && int'(a) >= 1024) ||
          (op == 2'b10 && (int'(a) + int'(len) > 1024 || int'(dst) + int'(len) > 1024));
    if (err) begin
      q.push_back(mk(0, 1, 1, 0, 0, 0, 0, old));
    end else if (op == 2'b00) begin
      q.push_back(mk(0, 0, 0, 0, 1, int'(a), 0, old));
      model_load = model_mem[a];
      q.push_back(mk(0, 1, 0, 0, 0, 0, 0, model_load));
    end else if (op == 2'b01) begin
      q.push_back(mk(0, 0, 0, 1, 1, int'(a), d, old));
      model_mem[a] = d;
      q.push_back(mk(0, 1, 0, 0, 0, 0, 0, old));
    end else begin
      for (int i = 0; i < int'(len); i++) begin
        v = model_mem[int'(a) + i];
        q.push_back(mk(0, 0, 0, 0, 1, int'(a) + i, 0, old));
        q.push_back(mk(0, 0, 0, 1, 1, int'(dst) + i, v, old));
        model_mem[int'(dst) + i] = v;
      end
      q.push_back(mk(0, 1, 0, 0, 0, 0, 0, old));
    end
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 200) begin @(posedge clk); t++; end
    if (q.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [9:0] a, input logic [31:0] d,
                       input logic [9:0] dst, input logic [9:0] len, input int hold);
    drain();
    @(negedge clk);
    request = 1'b1; operation = op; cpu_address = a; cpu_data = d;
    copy_dst = dst; copy_len = len;
    @(posedge clk); #1;
    accept_cyc = cyc; wpulse = 0;
    build(op, a, d, dst, len);
    for (int j = 0; j < hold; j++) begin
      @(negedge clk);
      operation = 2'($urandom); cpu_address = 10'($urandom); cpu_data = $urandom;
      copy_dst = 10'($urandom); copy_len = 10'($urandom);
    end
    @(negedge clk);
    request = 1'b0;
  endtask

  task automatic wait_idle();
    drain();
    @(negedge clk); #1;
  endtask

  task automatic preload(input int addr, input logic [31:0] val);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = 10'(addr); pre_data = val;
    model_mem[addr] = val;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_we"}, 32'(ram_we), 32'd0);
    chk({tag, "_load_data"}, load_data, 32'd0);
    chk({tag, "_ram_address"}, 32'(ram_address), 32'd0);
    chk({tag, "_ram_data_c"}, ram_data_c, 32'd0);
  endtask

  initial begin
    logic [31:0] orig203;
    logic [1:0]  op;
    logic [9:0]  a, dst, len;
    int          hold, bad;

    rst_n = 1'b0; request = 1'b0; operation = '0; cpu_address = '0; cpu_data = '0;
    copy_dst = '0; copy_len = '0; pre_we = 1'b0; pre_addr = '0; pre_data = '0; fill = 1'b1;
    for (int i = 0; i < 1024; i++) model_mem[i] = pat(i);
    @(posedge clk); #1 fill = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk); rst_n = 1'b1;
    #1 checking = 1;

    // Store then load at address 3.
    issue(2'b01, 10'd3, 32'h0000_00A5, 10'd0, 10'd0, 0);
    wait_idle();
    chk("store_we_pulses", 32'(wpulse), 32'd1);
    chk("store_latency", 32'(done_cyc - accept_cyc + 1), 32'd2);
    issue(2'b00, 10'd3, 32'h0, 10'd0, 10'd0, 0);
    wait_idle();
    chk("load_latency", 32'(done_cyc - accept_cyc + 1), 32'd2);
    chk("load_value", load_data, 32'h0000_00A5);
    chk("load_error", 32'(last_err), 32'd0);

    // Block copy of four words.
    preload(0, 32'd1); preload(1, 32'd3); preload(2, 32'd5); preload(3, 32'd9);
    issue(2'b10, 10'd0, 32'h0, 10'd10, 10'd4, 0);
    wait_idle();
    chk("copy_latency", 32'(done_cyc - accept_cyc + 1), 32'd9);
    chk("copy_we_pulses", 32'(wpulse), 32'd4);
    chk("copy_word10", ram[10], 32'd1);
    chk("copy_word11", ram[11], 32'd3);
    chk("copy_word12", ram[12], 32'd5);
    chk("copy_word13", ram[13], 32'd9);

    // Zero-length copy, then out-of-range copy.
    issue(2'b10, 10'd5, 32'h0, 10'd20, 10'd0, 0);
    wait_idle();
    chk("len0_latency", 32'(done_cyc - accept_cyc + 1), 32'd1);
    chk("len0_error", 32'(last_err), 32'd0);
    chk("len0_we_pulses", 32'(wpulse), 32'd0);
    issue(2'b10, 10'd1020, 32'h0, 10'd0, 10'd8, 0);
    wait_idle();
    chk("oor_copy_error", 32'(last_err), 32'd1);
    chk("oor_copy_we_pulses", 32'(wpulse), 32'd0);
    chk("oor_copy_latency", 32'(done_cyc - accept_cyc + 1), 32'd1);

    // Top address, illegal op, request held while busy.
    issue(2'b00, 10'd1023, 32'h0, 10'd0, 10'd0, 1);
    wait_idle();
    chk("load_top_error", 32'(last_err), 32'd0);
    chk("load_top_value", load_data, pat(1023));
    issue(2'b11, 10'd5, 32'h0, 10'd0, 10'd0, 0);
    wait_idle();
    chk("illegal_error", 32'(last_err), 32'd1);
    issue(2'b01, 10'd7, 32'h1234_5678, 10'd0, 10'd0, 1);
    wait_idle();
    chk("held_store_we_pulses", 32'(wpulse), 32'd1);
    chk("held_store_word", ram[7], 32'h1234_5678);

    // Overlapping copy replicates the first word.
    preload(0, 32'd7); preload(1, 32'd8); preload(2, 32'd9);
    issue(2'b10, 10'd0, 32'h0, 10'd1, 10'd3, 0);
    wait_idle();
    chk("overlap_word1", ram[1], 32'd7);
    chk("overlap_word2", ram[2], 32'd7);
    chk("overlap_word3", ram[3], 32'd7);

    // Reset during the write of word 2 of a 4-word copy.
    preload(100, 32'h11); preload(101, 32'h22); preload(102, 32'h33); preload(103, 32'h44);
    orig203 = model_mem[203];
    issue(2'b10, 10'd100, 32'h0, 10'd200, 10'd4, 0);
    repeat (5) @(negedge clk);
    #2 checking = 0; rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    q.delete();
    model_load = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 checking = 1;
    chk("midreset_word0", ram[200], 32'h11);
    chk("midreset_word1", ram[201], 32'h22);
    chk("midreset_word3", ram[203], orig203);
    model_mem[200] = 32'h11; model_mem[201] = 32'h22;
    model_mem[202] = ram[202]; model_mem[203] = orig203;

    // Random operations against the model.
    for (int k = 0; k < 300; k++) begin
      op  = 2'($urandom_range(0, 3));
      a   = 10'($urandom);
      dst = 10'($urandom);
      if ($urandom_range(0, 3) == 0) a = 10'($urandom_range(1016, 1023));
      if ($urandom_range(0, 3) == 0) dst = 10'($urandom_range(1016, 1023));
      len  = 10'($urandom_range(0, 8));
      hold = (op == 2'b00 || op == 2'b01) ? $urandom_range(0, 1) : 0;
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      issue(op, a, $urandom, dst, len, hold);
    end
    wait_idle();

    bad = 0;
    for (int i = 0; i < 1024; i++) if (ram[i] !== model_mem[i]) bad++;
    chk("ram_contents_mismatching_words", 32'(bad), 32'd0);

    checking = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
